// File: rtl/pwm_dc_ramp.sv
// pwm_dc_ramp
// Soft-start / slew-rate limiter feeding the 7-bit duty-cycle input of the pwm
// stage. A requested target (percent) is accepted over a valid/ready handshake
// and the registered dc output walks toward it by STEP once every TICK_DIV
// clocks, so the PWM output never sees an abrupt duty change.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   target_dc    in   [6:0] requested duty cycle, percent (values > DC_MAX clamp)
//   target_valid in   target_dc is valid this cycle
//   target_ready out  block can accept a target this cycle (~reset & ~hold)
//   hold         in   freeze ramp: dc, prescaler and state keep their value
//   dc           out  [6:0] registered duty cycle to the pwm stage
//   at_target    out  dc equals the captured target (state IDLE)
//   ramping      out  high while ramping up or down
module pwm_dc_ramp #(
   parameter int DC_MAX   = 100,
   parameter int STEP     = 1,
   parameter int TICK_DIV = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] target_dc,
   input  logic       target_valid,
   output logic       target_ready,
   input  logic       hold,
   output logic [6:0] dc,
   output logic       at_target,
   output logic       ramping
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      dc_q, dc_d;
   logic [6:0]      target_q, target_d;
   logic [PW-1:0]   presc_q, presc_d;

   logic            accept;
   logic            tick;
   logic [6:0]      target_clamped;
   logic [7:0]      up_sum;
   logic [7:0]      down_limit;

   assign target_ready   = ~reset & ~hold;
   assign accept         = target_valid & target_ready;
   assign tick           = (presc_q == PW'(TICK_DIV - 1)) & ~hold;
   assign target_clamped = (target_dc > 7'(DC_MAX)) ? 7'(DC_MAX) : target_dc;

   // 8-bit arithmetic so neither direction can wrap around the 7-bit range:
   // the up step saturates at the target, and the down step lands on the
   // target whenever dc - STEP would fall at or below it.
   assign up_sum     = {1'b0, dc_q} + 8'(STEP);
   assign down_limit = {1'b0, target_q} + 8'(STEP);

   always_comb begin
      state_d  = state_q;
      dc_d     = dc_q;
      target_d = target_q;
      presc_d  = presc_q;

      if (!hold) begin
         if (accept) begin
            // Acceptance wins over a coincident tick: dc stays put and the
            // prescaler restarts so the first step is a full period away.
            target_d = target_clamped;
            presc_d  = '0;
         end else begin
            case (state_q)
               RAMP_UP: begin
                  if (tick) begin
                     presc_d = '0;
                     dc_d    = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[6:0];
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
               RAMP_DOWN: begin
                  if (tick) begin
                     presc_d = '0;
                     dc_d    = ({1'b0, dc_q} <= down_limit) ? target_q : (dc_q - 7'(STEP));
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
               default: presc_d = '0;
            endcase
         end

         // Direction is always derived from where dc and the target will be,
         // so a mid-ramp target simply reverses course without a dc jump.
         if (dc_d < target_d) begin
            state_d = RAMP_UP;
         end else if (dc_d > target_d) begin
            state_d = RAMP_DOWN;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         dc_q     <= '0;
         target_q <= '0;
         presc_q  <= '0;
      end else begin
         state_q  <= state_d;
         dc_q     <= dc_d;
         target_q <= target_d;
         presc_q  <= presc_d;
      end
   end

   assign dc        = dc_q;
   assign at_target = (state_q == IDLE);
   assign ramping   = ~at_target;

endmodule
